// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-port arbiter in front of a single-ported data memory. Port 0 is the
//   pipeline MEM stage and port 1 is the DMA/debug loader. Each access takes
//   one memory cycle (ACCn) followed by a one-cycle ack pulse. Ties are
//   broken round-robin against the port served last.
//
// Ports
//   clk                     rising-edge clock
//   reset                   asynchronous, active-low reset
//   req0/req1               access request per port
//   addr0/addr1             byte address per port (forwarded undecoded)
//   wdata0/wdata1           write data per port
//   we0/we1                 1 = write, 0 = read
//   lb0/lb1                 byte-load qualifier per port
//   ack0/ack1               one-cycle completion pulse per port
//   rdata0/rdata1           read data captured at the end of a read
//   mem_addr/mem_wdata      address / write data to the memory
//   mem_read/mem_write      memory strobes, active only during ACCn
//   mem_is_lb               byte-load qualifier to the memory
//   mem_rdata               combinational read data from the memory
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lb0,
  input  logic              lb1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_is_lb,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              lat_lb;
  logic              valid0;
  logic              valid1;
  logic              grant0;
  logic              grant1;

  // A request seen during its own ack cycle is the tail of the access that
  // just finished, so it is masked for that one cycle.
  assign valid0 = req0 & ~ack0;
  assign valid1 = req1 & ~ack1;

  // Port 0 wins when it is alone, or on a tie when port 1 was served last.
  assign grant0 = (state == IDLE) & valid0 & (~valid1 | last_grant);
  assign grant1 = (state == IDLE) & valid1 & ~grant0;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant0)      state_next = ACC0;
        else if (grant1) state_next = ACC1;
      end
      ACC0, ACC1: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Memory-side outputs: address/data always reflect the latched request,
  // strobes only while an access is in flight.
  always_comb begin
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_is_lb = 1'b0;
    if (state == ACC0 || state == ACC1) begin
      mem_read  = ~lat_we;
      mem_write = lat_we;
      mem_is_lb = lat_lb;
    end
  end

  // Request latch, completion pulse, read capture and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      lat_lb     <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0) begin
            lat_addr  <= addr0;
            lat_wdata <= wdata0;
            lat_we    <= we0;
            lat_lb    <= lb0;
          end else if (grant1) begin
            lat_addr  <= addr1;
            lat_wdata <= wdata1;
            lat_we    <= we1;
            lat_lb    <= lb1;
          end
        end
        ACC0: begin
          ack0       <= 1'b1;
          last_grant <= 1'b0;
          if (!lat_we) rdata0 <= mem_rdata;
        end
        ACC1: begin
          ack1       <= 1'b1;
          last_grant <= 1'b1;
          if (!lat_we) rdata1 <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Directed scenarios for the arbiter followed by a randomized run checked
//   against a transaction-level reference model. A small behavioural memory
//   returns data as a fixed function of the address.
module tb_data_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          we0, we1, lb0, lb1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read, mem_write, mem_is_lb;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h0000_0008) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .lb0(lb0), .lb1(lb1),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_is_lb(mem_is_lb),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lb0 = 0; lb1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({mem_read, mem_write, mem_is_lb, ack0, ack1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_read, mem_write, mem_is_lb, ack0, ack1});
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata);
    end
    n_checks++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata0, rdata1);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    req0 = 1; we0 = 0; addr0 = 32'h8; lb0 = 1;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1 || mem_write !== 0 || mem_addr !== 32'h8 || mem_is_lb !== 1 || ack0 !== 0) begin
      n_fail++;
      $display("FAIL single_read_strobe: got rd=%b wr=%b addr=%h lb=%b ack0=%b expected 1 0 8 1 0",
               mem_read, mem_write, mem_addr, mem_is_lb, ack0);
    end
    req0 = 0;
    @(negedge clk);
    n_checks++;
    if (ack0 !== 1 || rdata0 !== 32'h1234_5678 || mem_read !== 0 || mem_is_lb !== 0) begin
      n_fail++;
      $display("FAIL single_read_ack: got ack0=%b rdata0=%h rd=%b lb=%b expected 1 12345678 0 0",
               ack0, rdata0, mem_read, mem_is_lb);
    end
    @(negedge clk);
    n_checks++;
    if (ack0 !== 0 || rdata0 !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL single_read_hold: got ack0=%b rdata0=%h expected 0 12345678", ack0, rdata0);
    end
  endtask

  task automatic test_reset_mid_access();
    req0 = 1; we0 = 1; addr0 = 32'h44; wdata0 = 32'h77;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got mem_write=%b expected 1", mem_write);
    end
    req0 = 0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (mem_write !== 0 || mem_addr !== '0 || rdata0 !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got wr=%b addr=%h rdata0=%h expected 0 0 0", mem_write, mem_addr, rdata0);
    end
    @(negedge clk);
    n_checks++;
    if (ack0 !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_noack: got ack0=%b expected 0", ack0);
    end
    reset = 1'b1;
    req0 = 1; we0 = 0; addr0 = 32'h20;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1 || mem_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL mid_reset_resume_strobe: got rd=%b addr=%h expected 1 20", mem_read, mem_addr);
    end
    req0 = 0;
    @(negedge clk);
    n_checks++;
    if (ack0 !== 1 || rdata0 !== mem_fn(32'h20)) begin
      n_fail++;
      $display("FAIL mid_reset_resume_ack: got ack0=%b rdata0=%h expected 1 %h", ack0, rdata0, mem_fn(32'h20));
    end
    @(negedge clk);
  endtask

  task automatic test_tie();
    do_reset();
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    addr0 = 32'h100; addr1 = 32'h200; wdata0 = 32'hA0; wdata1 = 32'hB1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (k % 2 == 1) begin
        if (mem_write !== 1 || mem_addr !== ((k % 4 == 1) ? addr0 : addr1) || ack0 !== 0 || ack1 !== 0) begin
          n_fail++;
          $display("FAIL tie_grant_k%0d: got wr=%b addr=%h acks=%b%b expected 1 %h 00",
                   k, mem_write, mem_addr, ack0, ack1, (k % 4 == 1) ? addr0 : addr1);
        end
      end else begin
        if (ack0 !== (k % 4 == 2) || ack1 !== (k % 4 == 0) || mem_write !== 0) begin
          n_fail++;
          $display("FAIL tie_ack_k%0d: got ack0=%b ack1=%b wr=%b expected %b %b 0",
                   k, ack0, ack1, mem_write, (k % 4 == 2), (k % 4 == 0));
        end
      end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_write_isolation();
    logic [DW-1:0] keep;
    int writes;
    int acks;
    keep = mem_fn(32'h4000_000C);
    req1 = 1; we1 = 0; addr1 = 32'h4000_000C;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1 || mem_addr !== 32'h4000_000C) begin
      n_fail++;
      $display("FAIL mmio_read_addr: got rd=%b addr=%h expected 1 4000000c", mem_read, mem_addr);
    end
    req1 = 0;
    @(negedge clk);
    n_checks++;
    if (ack1 !== 1 || rdata1 !== keep) begin
      n_fail++;
      $display("FAIL mmio_read_data: got ack1=%b rdata1=%h expected 1 %h", ack1, rdata1, keep);
    end
    @(negedge clk);
    req1 = 1; we1 = 1; addr1 = 32'h4000_0010; wdata1 = 32'hABC;
    writes = 0;
    acks = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (mem_write === 1) begin
        writes++;
        n_checks++;
        if (mem_addr !== 32'h4000_0010 || mem_wdata !== 32'hABC) begin
          n_fail++;
          $display("FAIL write_iso_bus: got addr=%h wdata=%h expected 40000010 abc", mem_addr, mem_wdata);
        end
      end
      if (ack1 === 1) acks++;
      if (k == 1) req1 = 0;
    end
    n_checks++;
    if (writes != 1 || acks != 1) begin
      n_fail++;
      $display("FAIL write_iso_count: got writes=%0d acks=%0d expected 1 1", writes, acks);
    end
    n_checks++;
    if (rdata1 !== keep) begin
      n_fail++;
      $display("FAIL write_iso_rdata: got rdata1=%h expected %h", rdata1, keep);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [4:0] rd_seen;
    logic [4:0] ack_seen;
    req0 = 1; we0 = 0; addr0 = 32'h30;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rd_seen[k-1]  = mem_read;
      ack_seen[k-1] = ack0;
      if (k == 4) req0 = 0;
    end
    n_checks++;
    if (rd_seen !== 5'b01001 || ack_seen !== 5'b10010) begin
      n_fail++;
      $display("FAIL back_to_back: got rd=%b ack0=%b (bit0=T+1) expected 01001 10010", rd_seen, ack_seen);
    end
    n_checks++;
    if (rdata0 !== mem_fn(32'h30)) begin
      n_fail++;
      $display("FAIL back_to_back_data: got %h expected %h", rdata0, mem_fn(32'h30));
    end
    @(negedge clk);
  endtask

  task automatic test_perturb();
    req0 = 1; we0 = 1; addr0 = 32'h100; wdata0 = 32'h5555; lb0 = 0;
    @(negedge clk);
    addr0 = 32'hDEAD_BEEF; wdata0 = 32'h1111; we0 = 0; req0 = 0;
    #1;
    n_checks++;
    if (mem_addr !== 32'h100 || mem_wdata !== 32'h5555 || mem_write !== 1 || mem_read !== 0) begin
      n_fail++;
      $display("FAIL perturb: got addr=%h wdata=%h wr=%b rd=%b expected 100 5555 1 0",
               mem_addr, mem_wdata, mem_write, mem_read);
    end
    @(negedge clk);
    n_checks++;
    if (ack0 !== 1) begin
      n_fail++;
      $display("FAIL perturb_ack: got ack0=%b expected 1", ack0);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    // Reference model: one in-flight transaction record plus per-port results.
    logic          busy;
    int            owner;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic          t_we, t_lb;
    logic          exp_ack[2];
    logic          nxt_ack[2];
    logic [DW-1:0] exp_rdata[2];
    int            last_served;
    logic          want[2];
    int            w;
    do_reset();
    busy = 0; owner = 0; t_addr = '0; t_wdata = '0; t_we = 0; t_lb = 0;
    exp_ack[0] = 0; exp_ack[1] = 0; exp_rdata[0] = '0; exp_rdata[1] = '0;
    last_served = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_read, mem_write, mem_is_lb} !== {busy & ~t_we, busy & t_we, busy & t_lb} ||
          mem_addr !== t_addr || mem_wdata !== t_wdata) begin
        n_fail++;
        $display("FAIL rand_mem cyc%0d: got rwl=%b%b%b addr=%h wdata=%h expected %b%b%b %h %h", cyc,
                 mem_read, mem_write, mem_is_lb, mem_addr, mem_wdata,
                 busy & ~t_we, busy & t_we, busy & t_lb, t_addr, t_wdata);
      end
      n_checks++;
      if (ack0 !== exp_ack[0] || ack1 !== exp_ack[1] || rdata0 !== exp_rdata[0] || rdata1 !== exp_rdata[1]) begin
        n_fail++;
        $display("FAIL rand_resp cyc%0d: got ack=%b%b rdata=%h/%h expected %b%b %h/%h", cyc,
                 ack0, ack1, rdata0, rdata1, exp_ack[0], exp_ack[1], exp_rdata[0], exp_rdata[1]);
      end
      n_checks++;
      if ((ack0 & ack1) !== 0 || (mem_read & mem_write) !== 0) begin
        n_fail++;
        $display("FAIL rand_exclusive cyc%0d: got acks=%b%b strobes=%b%b expected no pair",
                 cyc, ack0, ack1, mem_read, mem_write);
      end
      if (cyc < 590) begin
        req0 = ($urandom_range(0, 99) < 60); req1 = ($urandom_range(0, 99) < 60);
        we0 = ($urandom_range(0, 1) != 0);   we1 = ($urandom_range(0, 1) != 0);
        lb0 = ($urandom_range(0, 3) == 0);   lb1 = ($urandom_range(0, 3) == 0);
        addr0 = ($urandom_range(0, 7) == 0) ? 32'h4000_000C : $urandom;
        addr1 = ($urandom_range(0, 7) == 0) ? 32'h4000_0010 : $urandom;
        wdata0 = $urandom; wdata1 = $urandom;
      end else begin
        clear_inputs();
      end
      nxt_ack[0] = 0; nxt_ack[1] = 0;
      if (busy) begin
        nxt_ack[owner] = 1;
        if (!t_we) exp_rdata[owner] = mem_fn(t_addr);
        last_served = owner;
        busy = 0;
      end else begin
        want[0] = req0 && !exp_ack[0];
        want[1] = req1 && !exp_ack[1];
        if (want[0] || want[1]) begin
          if (want[0] && want[1]) w = 1 - last_served;
          else                    w = want[1] ? 1 : 0;
          busy = 1; owner = w;
          t_addr  = (w == 0) ? addr0 : addr1;
          t_wdata = (w == 0) ? wdata0 : wdata1;
          t_we    = (w == 0) ? we0 : we1;
          t_lb    = (w == 0) ? lb0 : lb1;
        end
      end
      exp_ack[0] = nxt_ack[0];
      exp_ack[1] = nxt_ack[1];
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_reset_mid_access();
    test_tie();
    test_write_isolation();
    test_back_to_back();
    test_perturb();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have ports req0/req1  input  1  request from port 0 (pipeline MEM stage) / port 1 (DMA/debug loader).
REQ-006 SHALL have ports addr0/addr1  input  ADDR_W  byte address per port.
REQ-007 SHALL have ports wdata0/wdata1  input  DATA_W  write data per port.
REQ-008 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-009 SHALL have ports lb0/lb1  input  1  byte-load qualifier per port.
REQ-010 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse per port.
REQ-011 SHALL have ports rdata0/rdata1  output  DATA_W  captured read data per port.
REQ-012 SHALL have port mem_addr  output  ADDR_W  address to the data memory.
REQ-013 SHALL have port mem_wdata  output  DATA_W  write data to the data memory.
REQ-014 SHALL have ports mem_read/mem_write  output  1  memory read/write strobes.
REQ-015 SHALL have port mem_is_lb  output  1  byte-load qualifier to the data memory.
REQ-016 SHALL have port mem_rdata  input  DATA_W  combinational read data from the data memory.

Function
REQ-017 SHALL implement the FSM states IDLE, ACC0 and ACC1.
REQ-018 SHALL, in IDLE, treat reqN as valid only when ackN = 0; a request presented during its own ack cycle is ignored for that cycle.
REQ-019 SHALL, in IDLE with exactly one valid request, grant that port.
REQ-020 SHALL, in IDLE with both requests valid, grant the port not in last_grant (round-robin).
REQ-021 SHALL, on grant, latch the winner's addr, wdata, we and lb into internal registers and enter ACCn on the next edge.
REQ-022 SHALL, in ACCn, drive mem_addr, mem_wdata and mem_is_lb from the latched registers, with mem_write = latched we and mem_read = ~latched we.
REQ-023 SHALL, in IDLE, drive mem_read, mem_write and mem_is_lb to 0; mem_addr and mem_wdata hold the latched values.
REQ-024 SHALL, at the end of ACCn, capture mem_rdata into rdataN on reads only; on writes rdataN is unchanged.
REQ-025 SHALL, at the end of ACCn, set ackN = 1 for exactly one cycle, set last_grant = N, and return to IDLE.
REQ-026 SHALL deliver ackN two cycles after reqN is first sampled in an uncontended IDLE (req at T, memory strobe at T+1, ack at T+2); peak throughput is one access per 2 cycles.
REQ-027 SHALL never assert ack0 and ack1 in the same cycle, and never assert mem_read and mem_write together.
REQ-028 SHALL hold rdataN stable between its own read completions.
REQ-029 SHALL forward addresses unmodified, including MMIO addresses 0x4000000C and 0x40000010; the arbiter does no address decoding.
REQ-030 SHALL ignore request-side input changes while in ACCn, because the latched copies are used.

Reset
REQ-031 SHALL, while reset = 0, force state = IDLE, last_grant = 1, ack0 = ack1 = 0, rdata0 = rdata1 = 0, all latched registers = 0 and all mem_* outputs = 0, independent of clk.
REQ-032 SHALL abort an in-flight ACCn immediately when reset is asserted mid-access, deasserting the strobes and suppressing its ack.
REQ-033 SHALL resume arbitration on the first rising clk edge after reset returns to 1, with port 0 winning the first tie.

Verification
REQ-034 SHALL cover single read: req0 = 1, we0 = 0, addr0 = 0x8, mem returns 0x12345678 -> mem_read = 1 at T+1, ack0 = 1 with rdata0 = 0x12345678 at T+2.
REQ-035 SHALL cover tie after reset: req0 = req1 = 1 held, both writes -> grants in order 0, 1, 0, 1, with ack0 at T+2, ack1 at T+4 and ack0 at T+6.
REQ-036 SHALL cover write isolation: req1 write addr1 = 0x40000010, wdata1 = 0xABC -> mem_write = 1, mem_addr = 0x40000010 for exactly one cycle, and rdata1 unchanged.
REQ-037 SHALL cover reset mid-access: reset = 0 during ACC0 -> mem_write = 0 immediately, no ack0; after release, a fresh req0 completes in 2 cycles.
REQ-038 SHALL cover back-to-back requests: req0 held through its ack -> request ignored in the ack cycle, second access ack0 at T+5.
REQ-039 SHALL cover input perturbation: addr0 changed during ACC0 -> mem_addr keeps the latched value.
